// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between the CPU data path (0) and the debug path (1).
// Grant is held for the whole transaction; completion returns ack, read data and a timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  sel,
  output logic                  busy
);

  // state | meaning
  // IDLE  | no transaction outstanding; arbitrate pending requests
  // BUSY  | memory access in flight for requester sel, timeout running
  // DONE  | one-cycle ack to requester sel; err/rdata carry the result

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t                state, state_nx;
  logic                  sel_nx;
  logic                  last, last_nx;
  logic [CW-1:0]         wait_cnt, wait_cnt_nx;
  logic [DATA_WIDTH-1:0] rdata_nx;
  logic                  err_nx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last     <= 1'b1;
      wait_cnt <= '0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      wait_cnt <= wait_cnt_nx;
      rdata    <= rdata_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    last_nx     = last;
    wait_cnt_nx = wait_cnt;
    rdata_nx    = rdata;
    err_nx      = err;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // on a tie the requester that did not win last time gets the port
          sel_nx      = (req0 && req1) ? ~last : req1;
          wait_cnt_nx = '0;
          state_nx    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          rdata_nx = mem_rdata;
          err_nx   = 1'b0;
          state_nx = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      DONE: begin
        last_nx  = sel;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // decoded from state so an async reset removes mem_req at once
  assign mem_req   = (state == BUSY);
  assign busy      = (state != IDLE);
  assign ack0      = (state == DONE) && !sel;
  assign ack1      = (state == DONE) &&  sel;
  assign mem_we    = mem_req && (sel ? we1 : we0);
  assign mem_addr  = mem_req ? (sel ? addr1 : addr0) : '0;
  assign mem_wdata = mem_req ? (sel ? wdata1 : wdata0) : '0;

endmodule
